// File: rtl/hamming74_secded_dec.sv
// -----------------------------------------------------------------------------
// hamming74_secded_dec
//
// Two-stage pipelined Hamming(7,4) SECDED decoder with valid/ready handshakes
// on both sides.
//   Stage 1 registers the raw codeword, the 3-bit syndrome and the overall
//           parity.
//   Stage 2 registers the corrected data nibble and the error class.
//
// Codeword layout: bit7 is the overall parity. Bits[6:0] hold Hamming
// positions 7..1, so bit k carries position k+1. The data nibble is
// {pos7, pos6, pos5, pos3}.
//
// Optional feature: define HAMMING_SECDED_ERR_CNT_EN to build three
// saturating error counters. When the macro is undefined, the counter outputs
// are tied to zero and i_cnt_clr is ignored.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_valid          input codeword valid
//   o_ready          decoder accepts a codeword this cycle
//   i_codeword[7:0]  SECDED codeword
//   o_valid          decoded result valid
//   i_ready          downstream accepts the result
//   o_data[3:0]      decoded (corrected) data
//   o_1bit_error     single error in positions 1..7, corrected
//   o_2bit_error     double error, data passed through uncorrected
//   o_parity_error   only the overall parity bit was flipped
//   i_cnt_clr        synchronous clear of all error counters
//   o_cnt_1bit, o_cnt_2bit, o_cnt_parity [CNT_W-1:0]  error counters
// -----------------------------------------------------------------------------
module hamming74_secded_dec #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [7:0]       i_codeword,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [3:0]       o_data,
  output logic             o_1bit_error,
  output logic             o_2bit_error,
  output logic             o_parity_error,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_cnt_1bit,
  output logic [CNT_W-1:0] o_cnt_2bit,
  output logic [CNT_W-1:0] o_cnt_parity
);

  // ---------------------------------------------------------------------------
  // Handshake: each stage advances when the stage after it can take its word.
  // ---------------------------------------------------------------------------
  logic adv1, adv2;

  // Stage 1 state
  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_cw_q,    s1_cw_d;
  logic [2:0] s1_syn_q,   s1_syn_d;
  logic       s1_par_q,   s1_par_d;

  // Stage 2 state (drives the outputs directly)
  logic       s2_valid_q, s2_valid_d;
  logic [3:0] s2_data_q,  s2_data_d;
  logic       s2_err1_q,  s2_err1_d;
  logic       s2_err2_q,  s2_err2_d;
  logic       s2_errp_q,  s2_errp_d;

  // Stage 2 decode results
  logic [6:0] corr;
  logic       syn_nz;

  assign adv2    = !s2_valid_q || i_ready;
  assign adv1    = !s1_valid_q || adv2;
  assign o_ready = adv1;

  // ---------------------------------------------------------------------------
  // Stage 1 next state: the syndrome bit for weight w is the XOR of every
  // position whose index has bit w set.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (adv1) begin
      s1_valid_d = i_valid;
    end
    if (adv1 && i_valid) begin
      s1_cw_d     = i_codeword;
      s1_syn_d[0] = i_codeword[0] ^ i_codeword[2] ^ i_codeword[4] ^ i_codeword[6];
      s1_syn_d[1] = i_codeword[1] ^ i_codeword[2] ^ i_codeword[5] ^ i_codeword[6];
      s1_syn_d[2] = i_codeword[3] ^ i_codeword[4] ^ i_codeword[5] ^ i_codeword[6];
      s1_par_d    = ^i_codeword;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 next state: classify and correct. A non-zero syndrome together
  // with odd overall parity names the single flipped position. A non-zero
  // syndrome with even parity is a double error, so the data is passed on
  // untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    syn_nz = (s1_syn_q != 3'd0);
    corr   = s1_cw_q[6:0];
    if (syn_nz && s1_par_q) begin
      corr = s1_cw_q[6:0] ^ (7'd1 << (s1_syn_q - 3'd1));
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err1_d  = s2_err1_q;
    s2_err2_d  = s2_err2_q;
    s2_errp_d  = s2_errp_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
    end
    // An empty stage 2 loads even while i_ready is low (adv2 is then true),
    // which collapses bubbles. The payload is only replaced by a real word.
    if (adv2 && s1_valid_q) begin
      s2_data_d = {corr[6], corr[5], corr[4], corr[2]};
      s2_err1_d = syn_nz && s1_par_q;
      s2_err2_d = syn_nz && !s1_par_q;
      s2_errp_d = !syn_nz && s1_par_q;
    end
  end

  // Valid bits, outputs and flags are cleared on reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others.
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 4'd0;
      s2_err1_q  <= 1'b0;
      s2_err2_q  <= 1'b0;
      s2_errp_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err1_q  <= s2_err1_d;
      s2_err2_q  <= s2_err2_d;
      s2_errp_q  <= s2_errp_d;
    end
  end

  // NOTE: the stage 1 payload has no reset. Its value is ignored while
  // s1_valid_q is low, so clearing it would only add reset fan-out.
  always_ff @(posedge i_clk) begin
    s1_cw_q  <= s1_cw_d;
    s1_syn_q <= s1_syn_d;
    s1_par_q <= s1_par_d;
  end

  assign o_valid        = s2_valid_q;
  assign o_data         = s2_data_q;
  assign o_1bit_error   = s2_err1_q;
  assign o_2bit_error   = s2_err2_q;
  assign o_parity_error = s2_errp_q;

  // ---------------------------------------------------------------------------
  // Error counters
  // ---------------------------------------------------------------------------
`ifdef HAMMING_SECDED_ERR_CNT_EN
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;
  logic [CNT_W-1:0] cntp_q, cntp_d;
  logic             fire;

  // Saturating increment: the counter stops at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign fire = s2_valid_q && i_ready;

  // A clear takes priority over an increment in the same cycle.
  always_comb begin
    cnt1_d = sat_inc(cnt1_q, fire && s2_err1_q);
    cnt2_d = sat_inc(cnt2_q, fire && s2_err2_q);
    cntp_d = sat_inc(cntp_q, fire && s2_errp_q);
    if (i_cnt_clr) begin
      cnt1_d = '0;
      cnt2_d = '0;
      cntp_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
      cntp_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      cntp_q <= cntp_d;
    end
  end

  assign o_cnt_1bit   = cnt1_q;
  assign o_cnt_2bit   = cnt2_q;
  assign o_cnt_parity = cntp_q;
`else
  // Counters are not built. The clear input is intentionally left unused.
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_cnt_clr;

  assign o_cnt_1bit   = '0;
  assign o_cnt_2bit   = '0;
  assign o_cnt_parity = '0;
`endif

endmodule

// File: tb/tb_hamming74_secded_dec.sv
// -----------------------------------------------------------------------------
// tb_hamming74_secded_dec
//
// Self-checking bench for hamming74_secded_dec, built with CNT_W = 2.
// The reference decoder finds the syndrome as the XOR of the indices of all
// set positions. A queue of in-flight words, each tagged with the edge on
// which it was accepted, predicts o_valid, o_ready and the output order.
// Expected counter values follow HAMMING_SECDED_ERR_CNT_EN.
// -----------------------------------------------------------------------------
module tb_hamming74_secded_dec;

  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef HAMMING_SECDED_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic                i_valid;
  logic                o_ready;
  logic [7:0]          i_codeword;
  logic                o_valid;
  logic                i_ready;
  logic [3:0]          o_data;
  logic                o_1bit_error;
  logic                o_2bit_error;
  logic                o_parity_error;
  logic                i_cnt_clr;
  logic [TB_CNT_W-1:0] o_cnt_1bit;
  logic [TB_CNT_W-1:0] o_cnt_2bit;
  logic [TB_CNT_W-1:0] o_cnt_parity;

  hamming74_secded_dec #(.CNT_W(TB_CNT_W)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_codeword     (i_codeword),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_1bit_error   (o_1bit_error),
    .o_2bit_error   (o_2bit_error),
    .o_parity_error (o_parity_error),
    .i_cnt_clr      (i_cnt_clr),
    .o_cnt_1bit     (o_cnt_1bit),
    .o_cnt_2bit     (o_cnt_2bit),
    .o_cnt_parity   (o_cnt_parity)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] flags;  // {1bit, 2bit, parity}
    int         acc;    // number of the edge that accepted the word
  } res_t;

  res_t sb[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;
  int   c1 = 0, c2 = 0, cp = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference decoder based on the Hamming rules.
  function automatic res_t ref_decode(input logic [7:0] cw);
    res_t       r;
    int         s = 0;
    logic       q;
    logic [7:0] w = cw;
    for (int p = 1; p <= 7; p++) if (cw[p-1]) s ^= p;
    q = ^cw;
    r.flags = 3'b000;
    r.acc   = 0;
    if (s != 0 && q) begin
      w[s-1]  = ~w[s-1];
      r.flags = 3'b100;
    end else if (s != 0) begin
      r.flags = 3'b010;
    end else if (q) begin
      r.flags = 3'b001;
    end
    r.data = {w[6], w[5], w[4], w[2]};
    return r;
  endfunction

  // Encoder: choose parity positions 1, 2 and 4 so that the syndrome is zero.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] w = 8'd0;
    int         s = 0;
    w[2] = d[0]; w[4] = d[1]; w[5] = d[2]; w[6] = d[3];
    for (int p = 1; p <= 7; p++) if (w[p-1]) s ^= p;
    w[0] = s[0]; w[1] = s[1]; w[3] = s[2];
    w[7] = ^w[6:0];
    return w;
  endfunction

  function automatic int sat(input int c);
    return (c < CNT_MAX) ? c + 1 : c;
  endfunction

  // One clock cycle. Entered and left at a falling edge.
  task automatic step(input logic v, input logic [7:0] cw, input logic rdy, input logic clr);
    logic exp_ov, exp_rdy;
    res_t r;
    i_valid = v; i_codeword = cw; i_ready = rdy; i_cnt_clr = clr;
    #1;
    exp_ov  = (sb.size() > 0) && (sb[0].acc <= cyc - 1);
    exp_rdy = !(sb.size() == 2 && !rdy);
    check("o_ready", o_ready, exp_rdy);
    check("o_valid", o_valid, exp_ov);
    if (exp_ov)
      check("result", {o_data, o_1bit_error, o_2bit_error, o_parity_error},
            {sb[0].data, sb[0].flags});
    check("counters", {o_cnt_1bit, o_cnt_2bit, o_cnt_parity},
          CNT_ON ? {c1[TB_CNT_W-1:0], c2[TB_CNT_W-1:0], cp[TB_CNT_W-1:0]} : '0);
    if (clr) begin
      c1 = 0; c2 = 0; cp = 0;
    end else if (exp_ov && rdy) begin
      if (sb[0].flags[2]) c1 = sat(c1);
      if (sb[0].flags[1]) c2 = sat(c2);
      if (sb[0].flags[0]) cp = sat(cp);
    end
    if (exp_ov && rdy) void'(sb.pop_front());
    if (v && exp_rdy) begin
      r = ref_decode(cw);
      r.acc = cyc + 1;
      sb.push_back(r);
    end
    @(posedge i_clk); cyc++;
    @(negedge i_clk);
  endtask

  // Single word: load it into the empty output stage while i_ready is low,
  // check it there, then release it and check the counters.
  task automatic directed(input string tag, input logic [7:0] cw,
                          input logic [3:0] d, input logic [2:0] f);
    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b1, cw, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check({tag, "_valid"}, o_valid, 1'b1);
    check({tag, "_data"}, o_data, d);
    check({tag, "_flags"}, {o_1bit_error, o_2bit_error, o_parity_error}, f);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check({tag, "_cnt"}, {o_cnt_1bit, o_cnt_2bit, o_cnt_parity},
          CNT_ON ? {{(TB_CNT_W-1){1'b0}}, f[2], {(TB_CNT_W-1){1'b0}}, f[1],
                    {(TB_CNT_W-1){1'b0}}, f[0]} : '0);
  endtask

  initial begin
    logic [7:0] w;
    int         k, b1, b2;

    i_rst_n = 1'b0; i_valid = 1'b1; i_codeword = 8'hFF; i_ready = 1'b0; i_cnt_clr = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); #1;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_outputs", {o_data, o_1bit_error, o_2bit_error, o_parity_error}, 7'd0);
    check("rst_counters", {o_cnt_1bit, o_cnt_2bit, o_cnt_parity}, '0);
    i_rst_n = 1'b1; i_valid = 1'b0;
    @(posedge i_clk); @(negedge i_clk); #1;
    check("ready_after_rst", o_ready, 1'b1);
    @(negedge i_clk);

    // All 16 clean codewords, starting with 8'h55, streamed back to back.
    // The word presented before an edge shows on o_valid after the following
    // edge, since it passes through two register stages.
    step(1'b1, encode(4'b1011), 1'b1, 1'b0);
    check("enc_55", encode(4'b1011), 8'h55);
    check("lat_stage1", o_valid, 1'b0);
    step(1'b1, encode(4'd0), 1'b1, 1'b0);
    check("lat_out", o_valid, 1'b1);
    check("lat_data", o_data, 4'b1011);
    for (int d = 1; d < 16; d++) step(1'b1, encode(d[3:0]), 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0);

    // Spec example words.
    directed("clean55", 8'h55, 4'b1011, 3'b000);
    directed("pos5",    8'h45, 4'b1011, 3'b100);
    directed("dbl12",   8'h56, 4'b1011, 3'b010);
    directed("parity",  8'hD5, 4'b1011, 3'b001);

    // Clear coincident with a parity-error result: the clear wins.
    step(1'b1, 8'hD5, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b1);
    check("clr_wins", o_cnt_parity, '0);

    // Saturation: four single-bit errors into a 2-bit counter.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h45, 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0);
    check("sat_1bit", o_cnt_1bit, CNT_ON ? TB_CNT_W'(CNT_MAX) : '0);

    // Random traffic with a toggling i_ready.
    for (int i = 0; i < 500; i++) begin
      w = encode(4'($urandom_range(0, 15)));
      k = $urandom_range(0, 3);
      b1 = $urandom_range(0, 7);
      b2 = (b1 + $urandom_range(1, 7)) % 8;
      if (k == 1) w[b1] = ~w[b1];
      if (k == 2) begin w[b1] = ~w[b1]; w[b2] = ~w[b2]; end
      if (k == 3) w = 8'($urandom_range(0, 255));
      step($urandom_range(0, 9) < 7, w, 1'($urandom_range(0, 1)),
           $urandom_range(0, 29) == 0);
    end
    repeat (4) step(1'b0, 8'd0, 1'b1, 1'b0);

    // Reset mid-stream with both stages full: nothing is emitted afterwards.
    step(1'b1, encode(4'd3), 1'b0, 1'b0);
    step(1'b1, encode(4'd5), 1'b0, 1'b0);
    step(1'b1, encode(4'd9), 1'b0, 1'b0);
    i_rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); cyc++;
    @(negedge i_clk); #1;
    check("midrst_o_valid", o_valid, 1'b0);
    check("midrst_o_ready", o_ready, 1'b1);
    sb.delete();
    c1 = 0; c2 = 0; cp = 0;
    i_rst_n = 1'b1; i_valid = 1'b0;
    @(negedge i_clk);
    repeat (4) step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b1, 8'h45, 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
